// File: rtl/mock_uart_mc.sv
// Multi-channel mock UART: APB register front end, per-channel TX FIFOs,
// round-robin drain onto one byte stream (tx_*), eol_o on a 0x0A handshake.
// Ports: clk_i, rst_i (sync, high); APB psel/penable/pwrite/paddr/pwdata,
// prdata/pready/pslverr; tx_valid_o/tx_ready_i/tx_chan_o/tx_data_o; eol_o.
module mock_uart_mc #(
  parameter int NumChannels = 4,
  parameter int FifoDepth   = 8,
  parameter int AddrWidth   = 32,
  parameter int DrainDiv    = 1,
  localparam int CW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [CW-1:0]        tx_chan_o,
  output logic [7:0]           tx_data_o,
  output logic                 eol_o
);

  localparam int PW  = $clog2(FifoDepth);
  localparam int CNW = PW + 1;
  localparam int DW  = (DrainDiv > 1) ? $clog2(DrainDiv) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [7:0]       r_mem  [NumChannels][FifoDepth];
  logic [PW-1:0]    r_wptr [NumChannels];
  logic [PW-1:0]    r_rptr [NumChannels];
  logic [CNW-1:0]   r_cnt  [NumChannels];
  logic [NumChannels-1:0] r_en;
  logic [NumChannels-1:0] r_ovf;

  state_t           r_state;
  logic             r_tx_valid;
  logic [CW-1:0]    r_tx_chan;
  logic [7:0]       r_tx_data;
  logic [CW-1:0]    r_ptr;
  logic [DW-1:0]    r_div;

  logic             w_acc;
  logic             w_bad;
  logic             w_wr;
  logic [3:0]       w_chan;
  logic [1:0]       w_off;
  logic [NumChannels-1:0] w_hit;
  logic [NumChannels-1:0] w_full;
  logic [NumChannels-1:0] w_empty;
  logic [NumChannels-1:0] w_push;
  logic [NumChannels-1:0] w_pop;
  logic [NumChannels-1:0] w_ovf_set;
  logic [NumChannels-1:0] w_ctrl_wr;
  logic [NumChannels-1:0] w_flush;
  logic [NumChannels-1:0] w_clr;
  logic             w_found;
  logic [CW-1:0]    w_sel;
  logic             w_do_pop;
  logic [7:0]       w_head;
  logic [31:0]      w_rdata;
  logic             w_full_sel;
  logic [CW-1:0]    w_ptr_nxt;
  logic             w_unused;

  assign w_unused = ^{pwdata_i[31:8], paddr_i[1:0]};

  assign w_chan = paddr_i[7:4];
  assign w_off  = paddr_i[3:2];
  assign w_acc  = psel_i & penable_i;
  assign w_bad  = ({1'b0, w_chan} >= 5'(NumChannels))
                | (|paddr_i[AddrWidth-1:8]);
  assign w_wr   = w_acc & pwrite_i & ~w_bad & ~rst_i;

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      w_hit[c]     = (w_chan == 4'(c));
      w_full[c]    = (r_cnt[c] == CNW'(FifoDepth));
      w_empty[c]   = (r_cnt[c] == '0);
      w_push[c]    = w_wr & w_hit[c] & (w_off == 2'd0) & ~w_full[c];
      w_ovf_set[c] = w_wr & w_hit[c] & (w_off == 2'd0) & w_full[c];
      w_ctrl_wr[c] = w_wr & w_hit[c] & (w_off == 2'd3);
      w_flush[c]   = w_ctrl_wr[c] & pwdata_i[1];
      w_clr[c]     = w_ctrl_wr[c] & pwdata_i[2];
      w_pop[c]     = w_do_pop & (w_sel == CW'(c));
    end
  end

  // First enabled, non-empty channel at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      idx = (int'(r_ptr) + i) % NumChannels;
      if (!w_found && r_en[idx] && !w_empty[idx]) begin
        w_found = 1'b1;
        w_sel   = CW'(idx);
      end
    end
  end

  assign w_do_pop = (r_state == S_IDLE) & (r_div == '0) & w_found;
  assign w_head   = r_mem[w_sel][r_rptr[w_sel]];
  assign w_ptr_nxt = (r_tx_chan == CW'(NumChannels - 1)) ? '0
                   : r_tx_chan + 1'b1;

  always_comb begin
    w_rdata    = '0;
    w_full_sel = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (w_hit[c]) begin
        w_full_sel = w_full[c];
        unique case (w_off)
          2'd0: w_rdata = '0;
          2'd1: w_rdata = {25'd0,
                  w_empty[c] & ~(r_tx_valid & (r_tx_chan == CW'(c))),
                  ~w_full[c], 2'b00, r_ovf[c], w_full[c], w_empty[c]};
          2'd2: w_rdata = 32'(r_cnt[c]);
          2'd3: w_rdata = {31'd0, r_en[c]};
          default: w_rdata = '0;
        endcase
      end
    end
  end

  assign pready_o  = w_acc;
  assign prdata_o  = (w_acc & ~w_bad & ~rst_i) ? w_rdata : '0;
  assign pslverr_o = w_acc & ~rst_i &
                     (w_bad | (pwrite_i & (w_off == 2'd0) & w_full_sel));

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (w_push[c]) r_mem[c][r_wptr[c]] <= pwdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (rst_i) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
        r_en[c]   <= 1'b1;
        r_ovf[c]  <= 1'b0;
      end else begin
        if (w_flush[c]) begin
          r_wptr[c] <= '0;
          r_rptr[c] <= '0;
          r_cnt[c]  <= '0;
        end else begin
          if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
          if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
          if (w_push[c] && !w_pop[c])
            r_cnt[c] <= r_cnt[c] + 1'b1;
          else if (w_pop[c] && !w_push[c])
            r_cnt[c] <= r_cnt[c] - 1'b1;
        end
        if (w_ctrl_wr[c]) r_en[c] <= pwdata_i[0];
        if (w_ovf_set[c])  r_ovf[c] <= 1'b1;
        else if (w_clr[c]) r_ovf[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_chan  <= '0;
      r_tx_data  <= '0;
      r_ptr      <= '0;
      r_div      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else if (w_found) begin
            r_tx_data  <= w_head;
            r_tx_chan  <= w_sel;
            r_tx_valid <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tx_ready_i) begin
            r_tx_valid <= 1'b0;
            r_ptr      <= w_ptr_nxt;
            r_div      <= DW'(DrainDiv - 1);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid_o = r_tx_valid;
  assign tx_chan_o  = r_tx_chan;
  assign tx_data_o  = r_tx_data;
  assign eol_o = r_tx_valid & tx_ready_i & ~rst_i & (r_tx_data == 8'h0A);

endmodule

// File: tb/tb_mock_uart_mc.sv
// Bench for mock_uart_mc: register table plus drain/overflow/reset sequences.
// Drives at negedge, samples shortly after; drained bytes logged to a queue.
module tb_mock_uart_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        tx_valid, tx_ready, eol;
  logic [1:0]  tx_chan;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  mock_uart_mc dut (
    .clk_i(clk), .rst_i(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .tx_chan_o(tx_chan), .tx_data_o(tx_data), .eol_o(eol)
  );

  int checks = 0;
  int failures = 0;
  int eol_cnt = 0;
  logic [15:0] q[$];

  always begin
    @(negedge clk);
    #2;
    if (!rst && tx_valid && tx_ready)
      q.push_back({6'd0, tx_chan, tx_data});
    if (eol) eol_cnt++;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit w, input logic [31:0] a, d, r,
                     input bit e);
    vec_t v;
    v.wr = w; v.addr = a; v.wd = d; v.rd = r; v.err = e;
    vt.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] a, e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic apb(input bit w, input logic [31:0] a, d,
                     output logic [31:0] r, output bit e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1;
    r = prdata;
    e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    bit er, acc;
    int e0;

    rst = 1'b1; psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; tx_ready = 0;
    cyc(3);
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_eol", 32'(eol), 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", 32'(pslverr), 0);
    chk("rst_pready", 32'(pready), 0);

    add(0, 32'h0C, 0, 32'h1, 0);
    add(0, 32'h04, 0, 32'h61, 0);
    add(0, 32'h08, 0, 32'h0, 0);
    add(0, 32'h3C, 0, 32'h1, 0);
    add(0, 32'h40, 0, 32'h0, 1);
    add(0, 32'h100, 0, 32'h0, 1);
    add(1, 32'h40, 32'h55, 0, 1);
    add(1, 32'h100, 32'h55, 0, 1);
    add(0, 32'h04, 0, 32'h61, 0);
    add(0, 32'h08, 0, 32'h0, 0);
    add(1, 32'h1C, 32'h0, 0, 0);
    add(0, 32'h1C, 0, 32'h0, 0);
    add(1, 32'h10, 32'h33, 0, 0);
    add(0, 32'h18, 0, 32'h1, 0);
    add(0, 32'h14, 0, 32'h20, 0);
    add(1, 32'h14, 32'hFF, 0, 0);
    add(0, 32'h18, 0, 32'h1, 0);
    add(1, 32'h1C, 32'h2, 0, 0);
    add(0, 32'h18, 0, 32'h0, 0);
    add(0, 32'h14, 0, 32'h61, 0);
    add(0, 32'h00, 0, 32'h0, 0);
    add(1, 32'h1C, 32'h1, 0, 0);
    add(0, 32'h1C, 0, 32'h1, 0);

    foreach (vt[i]) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wd, rd, er);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
      if (!vt[i].wr)
        chk($sformatf("vec%0d_rd", i), rd, vt[i].rd);
    end

    // single channel stream
    tx_ready = 1'b1;
    q.delete();
    e0 = eol_cnt;
    apb(1, 32'h00, 32'h48, rd, er);
    apb(1, 32'h00, 32'h69, rd, er);
    apb(1, 32'h00, 32'h0A, rd, er);
    cyc(20);
    chk("single_n", q.size(), 3);
    chk("single_0", 32'(q[0]), 32'h0048);
    chk("single_1", 32'(q[1]), 32'h0069);
    chk("single_2", 32'(q[2]), 32'h000A);
    chk("single_eol", eol_cnt - e0, 1);
    apb(0, 32'h04, 0, rd, er);
    chk("single_lsr", rd, 32'h61);

    // round-robin fairness
    tx_ready = 1'b0;
    q.delete();
    apb(1, 32'h00, 32'h41, rd, er);
    apb(1, 32'h00, 32'h42, rd, er);
    apb(1, 32'h20, 32'h43, rd, er);
    apb(1, 32'h20, 32'h44, rd, er);
    tx_ready = 1'b1;
    cyc(15);
    chk("rr_n", q.size(), 4);
    chk("rr_0", 32'(q[0]), 32'h0041);
    chk("rr_1", 32'(q[1]), 32'h0243);
    chk("rr_2", 32'(q[2]), 32'h0042);
    chk("rr_3", 32'(q[3]), 32'h0244);

    // overflow on ch1 while the engine is stuck on a ch0 byte
    tx_ready = 1'b0;
    q.delete();
    apb(1, 32'h00, 32'h5A, rd, er);
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apb(1, 32'h10, 32'(8'h10 + i), rd, er);
      acc |= er;
    end
    chk("ovf_first8_err", 32'(acc), 0);
    apb(1, 32'h10, 32'h99, rd, er);
    chk("ovf_9th_err", 32'(er), 1);
    apb(0, 32'h18, 0, rd, er);
    chk("ovf_cnt", rd, 8);
    apb(0, 32'h14, 0, rd, er);
    chk("ovf_lsr", rd, 32'h06);
    apb(1, 32'h1C, 32'h4, rd, er);
    chk("clr_err", 32'(er), 0);
    apb(0, 32'h14, 0, rd, er);
    chk("clr_lsr", rd, 32'h02);
    apb(0, 32'h1C, 0, rd, er);
    chk("clr_ctrl", rd, 0);
    apb(1, 32'h1C, 32'h1, rd, er);

    // backpressure: held byte stays put
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_stable", {21'd0, tx_valid, tx_chan, tx_data},
          {21'd0, 1'b1, 2'd0, 8'h5A});
    end
    apb(0, 32'h18, 0, rd, er);
    chk("hold_cnt1", rd, 8);
    apb(0, 32'h04, 0, rd, er);
    chk("hold_lsr0", rd, 32'h21);
    tx_ready = 1'b1;
    cyc(25);
    chk("bp_n", q.size(), 9);
    chk("bp_0", 32'(q[0]), 32'h005A);
    chk("bp_1", 32'(q[1]), 32'h0110);
    chk("bp_8", 32'(q[8]), 32'h0117);
    apb(0, 32'h18, 0, rd, er);
    chk("bp_cnt1", rd, 0);

    // disabled ch3 stays queued
    q.delete();
    apb(1, 32'h3C, 32'h0, rd, er);
    apb(1, 32'h30, 32'h70, rd, er);
    apb(1, 32'h20, 32'h71, rd, er);
    cyc(10);
    chk("dis_n", q.size(), 1);
    chk("dis_0", 32'(q[0]), 32'h0271);
    apb(0, 32'h38, 0, rd, er);
    chk("dis_cnt3", rd, 1);
    apb(1, 32'h3C, 32'h1, rd, er);
    cyc(10);
    chk("en_n", q.size(), 2);
    chk("en_1", 32'(q[1]), 32'h0370);
    apb(0, 32'h34, 0, rd, er);
    chk("en_lsr3", rd, 32'h61);

    // reset mid-drain
    tx_ready = 1'b0;
    q.delete();
    for (int i = 1; i <= 4; i++)
      apb(1, 32'h00, 32'(i), rd, er);
    apb(0, 32'h08, 0, rd, er);
    chk("pre_rst_cnt", rd, 3);
    apb(1, 32'h0C, 32'h0, rd, er);
    #1;
    chk("dis_keeps_hold", 32'(tx_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 0);
    apb(0, 32'h08, 0, rd, er);
    chk("mid_rst_cnt", rd, 0);
    apb(0, 32'h0C, 0, rd, er);
    chk("mid_rst_ctrl", rd, 1);
    apb(0, 32'h04, 0, rd, er);
    chk("mid_rst_lsr", rd, 32'h61);
    cyc(5);
    chk("mid_rst_noq", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mock_uart_mc.md
Name: mock_uart_mc

Overview:
- Testbench-only multi-channel mock UART with an APB slave front end.
- Sits behind the cluster's AXI-to-APB bridge in the bench. It replaces the single-channel, print-only mock UART.
- Each channel has a transmit FIFO, readable status and control registers, and sticky overflow detection.
- A round-robin drain engine serialises bytes from all channels onto one byte stream. The bench printer or scoreboard consumes this stream.

Parameters:
- NumChannels, 4, number of independent UART channels (1..16)
- FifoDepth, 8, TX FIFO entries per channel (power of two, >=2)
- AddrWidth, 32, APB address width
- DrainDiv, 1, minimum cycles between successive drained bytes (>=1; models baud throttling)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- pwrite_i  in  1  APB write
- paddr_i  in  AddrWidth  APB byte address
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- tx_valid_o  out  1  drained byte valid
- tx_ready_i  in  1  consumer ready
- tx_chan_o  out  max(1,$clog2(NumChannels))  source channel of drained byte
- tx_data_o  out  8  drained byte
- eol_o  out  1  one-cycle pulse when a 0x0A byte completes the tx handshake

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - All FIFOs empty.
  - Every channel's CTRL.enable = 1.
  - Overflow flags = 0.
  - Arbiter pointer = 0.
  - Divider counter = 0.
  - tx_valid_o = 0, eol_o = 0, prdata_o = 0, pslverr_o = 0.
  - pready_o is combinational and valid only while psel_i is high.
- Reset mid-operation: FIFO contents and any pending tx byte are discarded. No handshake completes in the reset cycle.
- APB timing:
  - Zero wait states: pready_o = psel_i & penable_i.
  - Register updates occur on the access-phase cycle.
  - prdata_o is combinational in the access phase and 0 otherwise.
- Address decode:
  - Channel index = paddr_i[7:4]; register offset = paddr_i[3:2].
  - Any access with channel >= NumChannels, or paddr_i[AddrWidth-1:8] != 0, returns pslverr_o = 1 and prdata_o = 0. No state changes.
- Register map (per channel, stride 0x10):
  - 0x0 THR: write pushes pwdata_i[7:0]; read returns 0.
  - 0x4 LSR (read-only):
    - bit0 = empty
    - bit1 = full
    - bit2 = overflow (sticky)
    - bit5 = !full
    - bit6 = empty & no pending tx byte from this channel
  - 0x8 CNT (read-only): FIFO occupancy, 0..FifoDepth.
  - 0xC CTRL:
    - bit0 enable (R/W).
    - bit1 flush (write-1 pulse; empties FIFO).
    - bit2 clr_ovf (write-1 pulse).
    - Reads return {30'b0, 1'b0, enable} in bits [1:0].
  - Writes to LSR/CNT are ignored without error.
- THR push rules:
  - Full is evaluated on the occupancy at the start of the cycle.
  - Push to a full FIFO drops the byte, sets overflow and returns pslverr_o = 1. This holds even if a pop occurs the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leave CNT unchanged.
  - Flush and push in the same cycle: flush wins and the byte is dropped without error.
  - Pointers wrap modulo FifoDepth; occupancy is a separate $clog2(FifoDepth)+1-bit counter.
- Drain engine:
  - Single output register with states IDLE and HOLD.
  - IDLE: when the divider counter is 0, select the first channel at or after the arbiter pointer that is enabled and non-empty. Pop its head into tx_data_o/tx_chan_o, assert tx_valid_o and go to HOLD. Popped byte is visible the next cycle.
  - HOLD: tx_valid_o is held stable until tx_ready_i. On handshake:
    - pointer = selected channel + 1 (mod NumChannels);
    - divider counter loads DrainDiv-1;
    - return to IDLE.
  - eol_o pulses on the handshake cycle if tx_data_o == 0x0A.
  - The divider counter decrements in IDLE while nonzero.
  - Back-to-back throughput with DrainDiv = 1 and tx_ready_i = 1 is one byte per 2 cycles.
  - Disabling a channel while its byte is in HOLD does not cancel that byte.
  - Flush does not cancel a HOLD byte.

Test Plan:
- Single channel: write 0x48,0x69,0x0A to ch0 THR, tx_ready_i = 1 -> stream (0,0x48),(0,0x69),(0,0x0A); eol_o pulses once; LSR reads 0x61 afterwards.
- Fairness: preload ch0 with 0x41,0x42 and ch2 with 0x43,0x44, then enable drain -> order ch0:0x41, ch2:0x43, ch0:0x42, ch2:0x44.
- Overflow (FifoDepth = 8, tx_ready_i = 0): push 9 bytes to ch1 -> 9th write has pslverr_o = 1 and CNT = 8; LSR bit2 = 1; CTRL write 0x4 clears it.
- Backpressure: tx_ready_i low for 5 cycles during HOLD -> tx_valid_o, tx_data_o and tx_chan_o stay stable; no pop until handshake.
- Decode errors (NumChannels = 4): access at 0x40 or 0x100 -> pslverr_o = 1, prdata_o = 0, no FIFO change. CTRL enable = 0 on ch3 -> ch3 bytes stay queued while other channels drain.
- Reset mid-drain: assert rst_i with ch0 holding 3 bytes and a HOLD byte -> next cycle tx_valid_o = 0, CNT = 0, CTRL reads 0x1.
